// File: rtl/unary_add_pkg.sv
// Shared types and helpers for the multi-input unary accumulator/emitter.
package unary_add_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to hold a count of ones across n one-bit streams.
  function automatic int popcnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational count of the ones present in the NUM_IN-bit input vector.
module unary_popcount
  import unary_add_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0]              din_i,
  output logic [popcnt_w(NUM_IN)-1:0]    cnt_o
);

  localparam int PCW = popcnt_w(NUM_IN);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_o = cnt_o + PCW'(din_i[i]);
    end
  end

endmodule

// File: rtl/unary_add_n.sv
// Multi-input unary accumulator: sums ones in read phase, replays them on dout in write phase.
// Build option: define UNARY_ADD_SAT_EN to saturate the count on overflow instead of wrapping.
module unary_add_n
  import unary_add_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              read_or_write,
  input  logic [NUM_IN-1:0] din,
  output logic              dout,
  output logic              C,
  output logic              busy,
  output logic              done,
  output state_e            state_o
);

  localparam int PCW = popcnt_w(NUM_IN);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;
  logic             rw_q;
  logic             dout_q;
  logic             c_q;
  logic             done_q;

  logic [PCW-1:0]   pop_cnt;
  logic [CNT_W:0]   sum_w;
  logic             ovf;
  logic [CNT_W-1:0] cnt_d;

  unary_popcount #(.NUM_IN(NUM_IN)) u_popcount (
    .din_i (din),
    .cnt_o (pop_cnt)
  );

  // One extra bit on the adder so the carry-out is the overflow indication.
  always_comb begin
    sum_w = {1'b0, cnt_q} + (CNT_W+1)'(pop_cnt);
    ovf   = sum_w[CNT_W];
`ifdef UNARY_ADD_SAT_EN
    cnt_d = ovf ? CNT_W'(cnt_max(CNT_W)) : sum_w[CNT_W-1:0];
`else
    cnt_d = sum_w[CNT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      rem_q   <= '0;
      rw_q    <= 1'b0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      // Frozen: hold everything, but never present a one or a done pulse.
      dout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rw_q   <= read_or_write;
      dout_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (read_or_write && !rw_q) begin
            state_q <= ST_EMIT;
            rem_q   <= cnt_q;
          end else if (!read_or_write) begin
            cnt_q <= cnt_d;
            if (ovf) c_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (rem_q != '0) begin
            dout_q <= 1'b1;
            rem_q  <= rem_q - CNT_W'(1);
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt_q   <= '0;
          c_q     <= 1'b0;
          state_q <= ST_ACCUM;
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign dout    = dout_q;
  assign C       = c_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_ACCUM);
  assign state_o = state_q;

endmodule

// File: doc/unary_add_n.md
# unary_add_n

Parametrised multi-input unary accumulator/emitter, the successor to the fixed two-input unary adder. It takes NUM_IN serial unary bit-streams and accumulates their total count of ones while in read phase. In write phase it replays the sum as a unary pulse train on dout, then signals completion. Its overflow flag and optional saturation make it usable as a chained stage in the unary arithmetic datapath.

## Interface
- NUM_IN, 2, number of unary input streams summed per cycle (≥1)
- CNT_W, 4, accumulator width; representable sum 0..2^CNT_W-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; 0 freezes all state
- read_or_write  in  1  0 = accumulate (read), 1 = emit (write)
- din  in  NUM_IN  one unary bit per stream per cycle
- dout  out  1  unary output stream, registered
- C  out  1  sticky overflow flag, registered
- busy  out  1  high in EMIT and DONE
- done  out  1  one-cycle pulse at end of emission

## Operation
- Reset values: dout=0, C=0, busy=0, done=0, cnt=0, rem=0, state=ACCUM, rw_q=0.
- States:
  - ACCUM: accumulates din.
  - EMIT: drives the pulse train.
  - DONE: single cycle, then returns to ACCUM.
- en=0: no state, counter or flag changes; dout forced 0 on that edge. done is not asserted while frozen.
- ACCUM, en=1, read_or_write=0:
  - sum = cnt + popcount(din), computed in CNT_W+1 bits.
  - If sum > 2^CNT_W-1, set C; C is sticky until DONE exits.
  - cnt takes the wrapped or saturated sum, per Configuration.
- ACCUM→EMIT: on the edge where read_or_write=1 and rw_q=0 (rising edge, en=1).
  - rem<=cnt.
  - din is ignored on that cycle.
- read_or_write held high in ACCUM without a fresh rising edge: no accumulation, no emission.
- EMIT, each enabled edge:
  - rem≠0: dout<=1, rem<=rem-1.
  - rem=0: dout<=0, done<=1, state<=DONE.
- read_or_write changes during EMIT are ignored, but rw_q keeps tracking.
- DONE, next enabled edge: done<=0, cnt<=0, C<=0, state<=ACCUM.
- Zero count: EMIT lasts one cycle with no ones, then DONE.
- rst mid-operation: all registers return to their reset values on that edge; any emission in progress is abandoned.

## Timing
- Accumulation latency: 1 cycle; cnt reflects din on the following edge.
- Edge E samples the rising read_or_write. dout=1 is visible after edges E+1..E+N for count N.
- done=1 is visible after edge E+N+1, for exactly one enabled cycle. dout=0 in that cycle.
- Enable pauses stretch the timing but never change the number of ones emitted.
- popcount width: $clog2(NUM_IN+1). Adder is purely combinational into the cnt register.

## Configuration
- UNARY_ADD_SAT_EN defined: on overflow, cnt saturates at 2^CNT_W-1 and C is set.
- UNARY_ADD_SAT_EN undefined: cnt wraps modulo 2^CNT_W and C is set.
- C behaviour is identical in both builds.

## Structure
- Package unary_add_pkg:
  - state enum {ACCUM, EMIT, DONE}
  - popcount width function
  - CNT_MAX constant function of CNT_W
- Sub-module unary_popcount (parameter NUM_IN): combinational count of ones in din. Instantiated once.

## Test plan
All cases use NUM_IN=2, CNT_W=4 unless stated.
- Reset: rst=1 for 2 cycles with din=2'b11, en=1 → dout=0, C=0, busy=0, done=0; first emission afterwards yields 0 ones.
- Normal sum: 7 cycles din=2'b11, then read_or_write 0→1 → exactly 14 consecutive dout ones, then done for 1 cycle, C=0, busy high throughout.
- Overflow: 8 cycles din=2'b11 (sum 16) → C=1.
  - Without UNARY_ADD_SAT_EN: 0 ones, then done.
  - With UNARY_ADD_SAT_EN: 15 ones, then done.
  - C clears after DONE in both builds.
- Enable pause: accumulate 5, start emit, drop en for 3 cycles after the 2nd one → dout=0 during the pause, 5 ones total, done delayed by 3 cycles.
- Handshake edges:
  - read_or_write held 1 after done → no second emission.
  - Toggle read_or_write 0→1 with no input → zero-length emission, single done pulse.
  - NUM_IN=3, din=3'b101 for 3 cycles → 6 ones.
- Reset mid-EMIT: rst after the 3rd of 10 ones → dout=0 and busy=0 after that edge; a fresh emission with no input gives 0 ones.
